// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer core: FSM state encoding and prescaler limit.
package timer_pkg;

  localparam int unsigned DIV_MAX_DEF = 8;
  // Prescaler limit width; supports exponents up to 15.
  localparam int unsigned LIM_W = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    RUN    = S_RUN,
    HALTED = S_HALTED,
    DONE   = S_DONE
  } tmr_state_t;

  // Terminal count of the prescaler: 2^min(div_val,div_max)-1, or 0 when undivided.
  function automatic logic [LIM_W-1:0] presc_lim(input logic div_en,
                                                  input logic [3:0] div_val,
                                                  input int unsigned div_max);
    int unsigned e;
    logic [31:0] full;
    e = (32'(div_val) > div_max) ? div_max : 32'(div_val);
    full = (32'd1 << e) - 32'd1;
    return div_en ? full[LIM_W-1:0] : '0;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler: emits a tick whenever the divide counter reaches the limit.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned DIV_MAX = DIV_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clr,
  input  logic       div_en,
  input  logic [3:0] div_val,
  output logic       tick
);

  logic [LIM_W-1:0] lim;
  logic [LIM_W-1:0] div_cnt_reg;
  logic [LIM_W-1:0] div_cnt_next;

  assign lim = presc_lim(div_en, div_val, DIV_MAX);
  // >= so that lowering the divisor mid-count ticks immediately rather than wrapping.
  assign tick = run && (div_cnt_reg >= lim);

  always_comb begin
    div_cnt_next = div_cnt_reg;
    if (clr) begin
      div_cnt_next = '0;
    end else if (run) begin
      div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
    end
  end

endmodule

// File: rtl/timer_cmp_counter.sv
// Timer core: run/halt/one-shot FSM, up-counter with reload, compare channels and sticky status.
module timer_cmp_counter
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned N_CMP   = 2,
  parameter int unsigned DIV_MAX = DIV_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             halt,
  input  logic             div_en,
  input  logic [3:0]       div_val,
  input  logic             auto_rld,
  input  logic             one_shot,
  input  logic             cnt_wr,
  input  logic [CNT_W-1:0] cnt_wdata,
  input  logic [N_CMP-1:0] cmp_wr,
  input  logic [CNT_W-1:0] cmp_wdata,
  input  logic [N_CMP:0]   int_en,
  input  logic [N_CMP:0]   int_clr,
  output logic [CNT_W-1:0] counter,
  output logic [N_CMP:0]   int_st,
  output logic             irq,
  output logic             tick,
  output logic             busy
);

  tmr_state_t       state_reg, state_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  logic [CNT_W-1:0] cmp_reg [N_CMP];
  logic [N_CMP:0]   int_st_reg, int_st_next;
  logic [N_CMP-1:0] match;
  logic             run, tick_w, reload, ovf;

  assign run = (state_reg == RUN) && !halt;

  timer_prescaler #(
    .DIV_MAX(DIV_MAX)
  ) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .clr    (state_reg == IDLE),
    .div_en (div_en),
    .div_val(div_val),
    .tick   (tick_w)
  );

  generate
    for (genvar gi = 0; gi < N_CMP; gi++) begin : g_cmp
      assign match[gi] = tick_w && !cnt_wr && (counter_reg == cmp_reg[gi]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cmp_reg[gi] <= '1;
        end else if (cmp_wr[gi]) begin
          cmp_reg[gi] <= cmp_wdata;
        end
      end
    end
  endgenerate

  // A reload takes the counter to 0 before it can wrap, so it never counts as overflow.
  assign reload = tick_w && auto_rld && (counter_reg == cmp_reg[0]);
  assign ovf    = tick_w && !cnt_wr && !reload && (&counter_reg);

  always_comb begin
    counter_next = counter_reg;
    if (cnt_wr) begin
      counter_next = cnt_wdata;
    end else if (reload) begin
      counter_next = '0;
    end else if (tick_w) begin
      counter_next = counter_reg + 1'b1;
    end
  end

  assign int_st_next = (int_st_reg & ~int_clr) | {ovf, match};

  always_comb begin
    state_next = state_reg;
    if (!timer_en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN: begin
          if (halt) begin
            state_next = HALTED;
          end else if (one_shot && match[0]) begin
            state_next = DONE;
          end
        end
        HALTED:  if (!halt) state_next = RUN;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      int_st_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      int_st_reg  <= int_st_next;
    end
  end

  assign counter = counter_reg;
  assign int_st  = int_st_reg;
  assign irq     = |(int_st_reg & int_en);
  assign tick    = tick_w;
  assign busy    = (state_reg == RUN) || (state_reg == HALTED);

endmodule
